// File: rtl/bt_uart_pkg.sv
// Shared types, line levels and helpers for the Bluetooth UART transmitter.
package bt_uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StStart = 2'd1;
  localparam state_t StData  = 2'd2;
  localparam state_t StStop  = 2'd3;

  localparam int unsigned DATA_BITS = 8;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bt_tx_fifo.sv
// Single-clock byte FIFO with registered ready; pushes are dropped when not ready.
module bt_tx_fifo
  import bt_uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 empty_o,
  output logic                 ready_o,
  output logic [CW-1:0]        count_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign wr_en   = push_i & ready_q;
  assign rd_en   = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = rd_en ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CW'(1);
    end
    // Ready tracks the post-edge occupancy so a pop at full still leaves it low this cycle.
    ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign ready_o = ready_q;
  assign count_o = count_q;

endmodule

// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter toward the Bluetooth module, fed by a byte FIFO and gated by cts_n.
module bt_uart_tx
  import bt_uart_pkg::*;
#(
  parameter  int unsigned CLK_HZ     = 100000000,
  parameter  int unsigned BAUD       = 9600,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned STOP_BITS  = 1,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic          cts_n,
  output logic          data_t,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned IW  = $clog2(DATA_BITS);

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 data_t_q, data_t_d;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 bit_end;
  logic                 frame_go;

  bt_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .ready_o (tx_ready),
    .count_o (fifo_count)
  );

  assign bit_end  = (baud_q == BW'(CPB - 1));
  assign frame_go = ~fifo_empty & ~cts_n;

  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == StIdle || bit_end) ? '0 : baud_q + BW'(1);
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (frame_go) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            stop_d  = 1'b0;
            state_d = StStop;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit so queued bytes leave no idle gap.
            if (frame_go) begin
              pop     = 1'b1;
              shift_d = fifo_rdata;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The line level is registered from the current state, one cycle behind the FSM.
  always_comb begin
    case (state_q)
      StStart: data_t_d = START_LVL;
      StData:  data_t_d = shift_q[idx_q];
      StStop:  data_t_d = STOP_LVL;
      default: data_t_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      data_t_q <= IDLE_LVL;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      data_t_q <= data_t_d;
    end
  end

  assign data_t = data_t_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_bt_uart_tx.sv
// Directed bench for bt_uart_tx at 10 clocks per bit; a second instance covers two stop bits.
module tb_bt_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cts_n;
  logic       data_t;
  logic       busy;
  logic [4:0] fifo_count;

  logic [7:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2;
  logic       cts_n2;
  logic       data_t2;
  logic       busy2;
  logic [4:0] fifo_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bt_uart_tx #(
    .CLK_HZ     (96000),
    .BAUD       (9600),
    .FIFO_DEPTH (16),
    .STOP_BITS  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cts_n      (cts_n),
    .data_t     (data_t),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  bt_uart_tx #(
    .CLK_HZ     (96000),
    .BAUD       (9600),
    .FIFO_DEPTH (16),
    .STOP_BITS  (2)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .cts_n      (cts_n2),
    .data_t     (data_t2),
    .busy       (busy2),
    .fifo_count (fifo_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge where the start bit appeared (k=0).
  task automatic expect_frame(input logic [7:0] b, input int sb, input bit sel,
                              input bit last, input int cts_at);
    int len;
    len = 10 * (9 + sb);
    for (int k = 0; k < len; k++) begin
      int   j;
      logic e;
      j = k / 10;
      if (j == 0) e = 1'b0;
      else if (j <= 8) e = b[j-1];
      else e = 1'b1;
      if (k % 10 == 0 || k % 10 == 9) chk($sformatf("frame_%02h_k%0d", b, k), sel ? data_t2 : data_t, e);
      if (k == len - 2) chk("frame_busy", sel ? busy2 : busy, 1);
      if (k == len - 1) chk("frame_busy_end", sel ? busy2 : busy, last ? 0 : 1);
      if (k == cts_at) cts_n = 1'b1;
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q [17];
    int         stuck;

    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; cts_n = 1'b0;
    tx_data2 = '0; tx_valid2 = 1'b0; cts_n2 = 1'b0;
    for (int i = 0; i < 16; i++) q[i] = 8'(i * 29 + 7);
    q[16] = 8'hEE;

    // Reset state
    tick(); tick();
    chk("rst_data_t", data_t, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", tx_ready, 1);

    // 1: single byte 0x58
    tx_data = 8'h58; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("t1_count_push", fifo_count, 1);
    chk("t1_busy_push", busy, 0);
    tick();
    chk("t1_busy_pop", busy, 1);
    chk("t1_count_pop", fifo_count, 0);
    chk("t1_line_pop", data_t, 1);
    tick();
    expect_frame(8'h58, 1, 1'b0, 1'b1, -1);
    chk("t1_idle_line", data_t, 1);

    // 2: back-to-back 0x00, 0xFF, 0xA5
    tx_valid = 1'b1; tx_data = 8'h00;
    tick();
    chk("t2_count0", fifo_count, 1);
    tx_data = 8'hFF;
    tick();
    chk("t2_count1", fifo_count, 1);
    tx_data = 8'hA5;
    tick();
    tx_valid = 1'b0;
    chk("t2_count2", fifo_count, 2);
    expect_frame(8'h00, 1, 1'b0, 1'b0, -1);
    expect_frame(8'hFF, 1, 1'b0, 1'b0, -1);
    expect_frame(8'hA5, 1, 1'b0, 1'b1, -1);
    chk("t2_count_end", fifo_count, 0);

    // 3: fill the FIFO while cts_n holds transmission off
    cts_n = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = q[i];
      tick();
    end
    chk("t3_count_full", fifo_count, 16);
    chk("t3_ready_full", tx_ready, 0);
    tx_data = q[16];
    tick(); tick();
    chk("t3_count_held", fifo_count, 16);
    chk("t3_line_held", data_t, 1);
    chk("t3_busy_held", busy, 0);
    cts_n = 1'b0;
    tick();
    chk("t3_busy_go", busy, 1);
    chk("t3_count_pop", fifo_count, 15);
    chk("t3_ready_pop", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    chk("t3_count_17th", fifo_count, 16);
    chk("t3_ready_17th", tx_ready, 0);
    for (int i = 0; i < 17; i++) expect_frame(q[i], 1, 1'b0, i == 16, -1);
    chk("t3_count_end", fifo_count, 0);

    // 4: cts_n deasserted mid-frame
    tx_valid = 1'b1; tx_data = 8'h3C;
    tick();
    tx_data = 8'h42;
    tick();
    tx_valid = 1'b0;
    tick();
    expect_frame(8'h3C, 1, 1'b0, 1'b1, 30);
    for (int i = 0; i < 19; i++) tick();
    chk("t4_line_wait", data_t, 1);
    chk("t4_busy_wait", busy, 0);
    chk("t4_count_wait", fifo_count, 1);
    cts_n = 1'b0;
    tick();
    chk("t4_busy_go", busy, 1);
    chk("t4_line_go", data_t, 1);
    chk("t4_count_go", fifo_count, 0);
    tick();
    expect_frame(8'h42, 1, 1'b0, 1'b1, -1);

    // 5: reset at bit 4 of 0x81 with three bytes queued
    tx_valid = 1'b1; tx_data = 8'h81;
    tick();
    tx_data = 8'h11;
    tick();
    tx_data = 8'h22;
    tick();
    tx_data = 8'h33;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 54; i++) tick();
    chk("t5_bit4", data_t, 0);
    chk("t5_count_q", fifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_line_rst", data_t, 1);
    chk("t5_count_rst", fifo_count, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_ready_rst", tx_ready, 0);
    tick();
    chk("t5_ready_after", tx_ready, 1);
    stuck = 0;
    for (int i = 0; i < 150; i++) begin
      if (data_t !== 1'b1 || busy !== 1'b0) stuck++;
      tick();
    end
    chk("t5_quiet", stuck, 0);

    // 6: two stop bits on the second instance
    chk("t6_ready", tx_ready2, 1);
    tx_valid2 = 1'b1; tx_data2 = 8'h55;
    tick();
    tx_valid2 = 1'b0;
    tick();
    chk("t6_busy_pop", busy2, 1);
    chk("t6_line_pop", data_t2, 1);
    tick();
    expect_frame(8'h55, 2, 1'b1, 1'b1, -1);
    chk("t6_idle_line", data_t2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
